// File: rtl/au_pkg.sv
// Shared opcodes and FSM state encoding for the parametrised arithmetic unit.
package au_pkg;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_DIV = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_EXEC = 2'b01,
        ST_DONE = 2'b10
    } au_state_e;

endpackage

// File: rtl/au_iter_core.sv
// Iterative datapath: shift-add multiplier and restoring divider, one step per enable.
// Next-step values are exposed so the caller can capture the final step's result at the same edge.
module au_iter_core #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load_i,
    input  logic               en_i,
    input  logic [WIDTH-1:0]   a_i,
    input  logic [WIDTH-1:0]   b_i,
    output logic [2*WIDTH-1:0] prod_nxt_o,
    output logic [WIDTH-1:0]   quot_nxt_o,
    output logic [WIDTH-1:0]   rem_nxt_o
);

    logic [WIDTH-1:0]   mcand_q;
    logic [WIDTH-1:0]   dvsr_q;
    logic [2*WIDTH-1:0] prod_q;
    logic [2*WIDTH-1:0] prod_d;
    logic [WIDTH-1:0]   quot_q;
    logic [WIDTH-1:0]   quot_d;
    logic [WIDTH-1:0]   rem_q;
    logic [WIDTH-1:0]   rem_d;
    logic [WIDTH:0]     partial_s;
    logic [WIDTH:0]     shifted_s;
    logic [WIDTH:0]     trial_s;
    logic               ge_s;

    // One multiply and one divide step computed from the current partial registers.
    always_comb begin
        partial_s = {1'b0, prod_q[2*WIDTH-1:WIDTH]};
        if (prod_q[0]) begin
            partial_s = partial_s + {1'b0, mcand_q};
        end else begin
            partial_s = partial_s + {(WIDTH+1){1'b0}};
        end
        prod_d = {partial_s, prod_q[WIDTH-1:1]};

        // Remainder stays below the divisor, so a trial that does not wrap fits in WIDTH bits.
        shifted_s = {rem_q, quot_q[WIDTH-1]};
        trial_s   = shifted_s - {1'b0, dvsr_q};
        ge_s      = ~trial_s[WIDTH];
        if (ge_s) begin
            rem_d = trial_s[WIDTH-1:0];
        end else begin
            rem_d = shifted_s[WIDTH-1:0];
        end
        quot_d = {quot_q[WIDTH-2:0], ge_s};
    end

    assign prod_nxt_o = prod_d;
    assign quot_nxt_o = quot_d;
    assign rem_nxt_o  = rem_d;

    // Partial registers: seeded on load, advanced one step per enable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand_q <= {WIDTH{1'b0}};
            dvsr_q  <= {WIDTH{1'b0}};
            prod_q  <= {(2*WIDTH){1'b0}};
            quot_q  <= {WIDTH{1'b0}};
            rem_q   <= {WIDTH{1'b0}};
        end else if (load_i) begin
            mcand_q <= a_i;
            dvsr_q  <= b_i;
            prod_q  <= {{WIDTH{1'b0}}, b_i};
            quot_q  <= a_i;
            rem_q   <= {WIDTH{1'b0}};
        end else if (en_i) begin
            prod_q  <= prod_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
        end else begin
            prod_q  <= prod_q;
        end
    end

endmodule

// File: rtl/au_multi_cycle_param.sv
// Parametrised multi-cycle arithmetic unit: ADD/SUB in one cycle, MUL/DIV over WIDTH iterations,
// start/busy/done handshake and explicit divide-by-zero flag.
module au_multi_cycle_param
    import au_pkg::*;
#(
    parameter int WIDTH = 8,
    localparam int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic [1:0]         ctrl,
    output logic [2*WIDTH-1:0] y,
    output logic               c,
    output logic               err,
    output logic               busy,
    output logic               done
);

    au_state_e          state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [1:0]         op_q, op_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2*WIDTH-1:0] y_q, y_d;
    logic               c_q, c_d;
    logic               err_q, err_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               load_s;
    logic               en_s;
    logic               last_s;
    logic [WIDTH:0]     add_s;
    logic [WIDTH:0]     sub_s;
    logic [2*WIDTH-1:0] prod_nxt_s;
    logic [WIDTH-1:0]   quot_nxt_s;
    logic [WIDTH-1:0]   rem_nxt_s;

    assign add_s  = {1'b0, a_q} + {1'b0, b_q};
    assign sub_s  = {1'b0, a_q} - {1'b0, b_q};
    assign last_s = (cnt_q == CNT_W'(WIDTH - 1));

    au_iter_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .clk        (clk),
        .rst_n      (reset),
        .load_i     (load_s),
        .en_i       (en_s),
        .a_i        (a),
        .b_i        (b),
        .prod_nxt_o (prod_nxt_s),
        .quot_nxt_o (quot_nxt_s),
        .rem_nxt_o  (rem_nxt_s)
    );

    // FSM next state, operand capture, iteration control and result formation.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        cnt_d   = cnt_q;
        y_d     = y_q;
        c_d     = c_q;
        err_d   = err_q;
        load_s  = 1'b0;
        en_s    = 1'b0;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    op_d    = ctrl;
                    cnt_d   = {CNT_W{1'b0}};
                    load_s  = 1'b1;
                    state_d = ST_EXEC;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_EXEC: begin
                case (op_q)
                    OP_ADD: begin
                        y_d     = {{WIDTH{1'b0}}, add_s[WIDTH-1:0]};
                        c_d     = add_s[WIDTH];
                        err_d   = 1'b0;
                        state_d = ST_DONE;
                    end
                    OP_SUB: begin
                        // The wrapped top bit of the extended difference is exactly a<b.
                        y_d     = {{WIDTH{1'b0}}, sub_s[WIDTH-1:0]};
                        c_d     = sub_s[WIDTH];
                        err_d   = 1'b0;
                        state_d = ST_DONE;
                    end
                    OP_MUL: begin
                        en_s = 1'b1;
                        if (last_s) begin
                            y_d     = prod_nxt_s;
                            c_d     = 1'b0;
                            err_d   = 1'b0;
                            state_d = ST_DONE;
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end
                    OP_DIV: begin
                        if (b_q == {WIDTH{1'b0}}) begin
                            y_d     = {a_q, {WIDTH{1'b1}}};
                            c_d     = 1'b0;
                            err_d   = 1'b1;
                            state_d = ST_DONE;
                        end else begin
                            en_s = 1'b1;
                            if (last_s) begin
                                y_d     = {rem_nxt_s, quot_nxt_s};
                                c_d     = 1'b0;
                                err_d   = 1'b0;
                                state_d = ST_DONE;
                            end else begin
                                cnt_d = cnt_q + CNT_W'(1);
                            end
                        end
                    end
                    default: begin
                        state_d = ST_IDLE;
                    end
                endcase
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d == ST_EXEC);
        done_d = (state_d == ST_DONE);
    end

    // State, operand and result registers; reset aborts any operation in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            a_q     <= {WIDTH{1'b0}};
            b_q     <= {WIDTH{1'b0}};
            op_q    <= 2'b00;
            cnt_q   <= {CNT_W{1'b0}};
            y_q     <= {(2*WIDTH){1'b0}};
            c_q     <= 1'b0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            cnt_q   <= cnt_d;
            y_q     <= y_d;
            c_q     <= c_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign y    = y_q;
    assign c    = c_q;
    assign err  = err_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_au_multi_cycle_param.sv
// Scoreboard bench: drivers push expected results, per-instance monitors pop and compare on done.
// Covers WIDTH=8 operations, mid-operation control, reset abort, back-to-back issue and WIDTH=2.
module tb_au_multi_cycle_param;

    typedef struct {
        logic [15:0] y;
        logic        c;
        logic        e;
        int          lat;
        int          acc;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start1 = 1'b0, start2 = 1'b0;
    logic [7:0]  a1 = 8'd0, b1 = 8'd0;
    logic [1:0]  a2 = 2'd0, b2 = 2'd0;
    logic [1:0]  ctrl1 = 2'd0, ctrl2 = 2'd0;
    logic [15:0] y1;
    logic [3:0]  y2;
    logic        c1, err1, busy1, done1;
    logic        c2, err2, busy2, done2;

    int   cyc = 0;
    int   vecs = 0;
    int   miss = 0;
    exp_t q1[$];
    exp_t q2[$];
    int   dcyc[$];

    au_multi_cycle_param #(.WIDTH(8)) u_dut8 (
        .clk(clk), .reset(reset), .start(start1), .a(a1), .b(b1), .ctrl(ctrl1),
        .y(y1), .c(c1), .err(err1), .busy(busy1), .done(done1)
    );

    au_multi_cycle_param #(.WIDTH(2)) u_dut2 (
        .clk(clk), .reset(reset), .start(start2), .a(a2), .b(b2), .ctrl(ctrl2),
        .y(y2), .c(c2), .err(err2), .busy(busy2), .done(done2)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vecs++;
        if (act !== exp) begin
            miss++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Monitor for the WIDTH=8 instance.
    always @(negedge clk) begin
        if (done1) begin
            dcyc.push_back(cyc);
            if (q1.size() == 0) begin
                check("w8_unexpected_done", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = q1.pop_front();
                check("w8_y", {16'd0, y1}, {16'd0, e.y});
                check("w8_c", {31'd0, c1}, {31'd0, e.c});
                check("w8_err", {31'd0, err1}, {31'd0, e.e});
                check("w8_latency", cyc - e.acc, e.lat);
                check("w8_busy_at_done", {31'd0, busy1}, 32'd0);
            end
        end
    end

    // Monitor for the WIDTH=2 instance.
    always @(negedge clk) begin
        if (done2) begin
            if (q2.size() == 0) begin
                check("w2_unexpected_done", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = q2.pop_front();
                check("w2_y", {28'd0, y2}, {16'd0, e.y});
                check("w2_c", {31'd0, c2}, {31'd0, e.c});
                check("w2_latency", cyc - e.acc, e.lat);
            end
        end
    end

    task automatic issue8(input logic [1:0] op, input logic [7:0] av, input logic [7:0] bv,
                          input logic [15:0] ey, input logic ec, input logic ee, input int lat);
        exp_t e;
        ctrl1 = op; a1 = av; b1 = bv; start1 = 1'b1;
        @(posedge clk); #1;
        start1 = 1'b0;
        e.y = ey; e.c = ec; e.e = ee; e.lat = lat; e.acc = cyc;
        q1.push_back(e);
    endtask

    task automatic issue2(input logic [1:0] op, input logic [1:0] av, input logic [1:0] bv,
                          input logic [15:0] ey, input logic ec, input int lat);
        exp_t e;
        ctrl2 = op; a2 = av; b2 = bv; start2 = 1'b1;
        @(posedge clk); #1;
        start2 = 1'b0;
        e.y = ey; e.c = ec; e.e = 1'b0; e.lat = lat; e.acc = cyc;
        q2.push_back(e);
    endtask

    // Waits for done on the selected instance; busy must stay high until then.
    task automatic wait_done(input int sel, input string nm);
        logic seen;
        logic busy_ok;
        seen = 1'b0;
        busy_ok = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if ((sel == 0) ? done1 : done2) begin
                seen = 1'b1;
                break;
            end else if (!((sel == 0) ? busy1 : busy2)) begin
                busy_ok = 1'b0;
            end else begin
                busy_ok = busy_ok;
            end
        end
        if (!seen) begin
            $display("FAIL %s_timeout: no done within 40 cycles", nm);
            miss++;
            vecs++;
        end
        check({nm, "_busy_until_done"}, {31'd0, busy_ok}, 32'd1);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs_w8", {12'd0, y1, c1, err1, busy1, done1}, 32'd0);
        reset = 1'b1;
        @(posedge clk); #1;
        check("post_reset_w8", {12'd0, y1, c1, err1, busy1, done1}, 32'd0);
        check("post_reset_w2", {24'd0, y2, c2, err2, busy2, done2}, 32'd0);

        issue8(2'b00, 8'd200, 8'd100, 16'd44, 1'b1, 1'b0, 1);       wait_done(0, "add_200_100");
        issue8(2'b01, 8'd5, 8'd9, 16'd252, 1'b1, 1'b0, 1);          wait_done(0, "sub_5_9");
        issue8(2'b01, 8'd9, 8'd5, 16'd4, 1'b0, 1'b0, 1);            wait_done(0, "sub_9_5");
        issue8(2'b10, 8'd255, 8'd255, 16'd65025, 1'b0, 1'b0, 8);    wait_done(0, "mul_255_255");
        issue8(2'b11, 8'd200, 8'd7, 16'h041C, 1'b0, 1'b0, 8);       wait_done(0, "div_200_7");
        issue8(2'b11, 8'd200, 8'd0, 16'hC8FF, 1'b0, 1'b1, 1);       wait_done(0, "div_200_0");
        issue8(2'b00, 8'd0, 8'd0, 16'd0, 1'b0, 1'b0, 1);            wait_done(0, "add_0_0");
        issue8(2'b01, 8'd0, 8'd0, 16'd0, 1'b0, 1'b0, 1);            wait_done(0, "sub_0_0");
        issue8(2'b10, 8'd0, 8'd0, 16'd0, 1'b0, 1'b0, 8);            wait_done(0, "mul_0_0");
        issue8(2'b11, 8'd0, 8'd0, 16'h00FF, 1'b0, 1'b1, 1);         wait_done(0, "div_0_0");
        issue8(2'b11, 8'd255, 8'd16, 16'h0F0F, 1'b0, 1'b0, 8);      wait_done(0, "div_255_16");
        issue8(2'b10, 8'd13, 8'd11, 16'd143, 1'b0, 1'b0, 8);        wait_done(0, "mul_13_11");

        // Operand, opcode and start activity while busy must be ignored.
        issue8(2'b10, 8'd3, 8'd4, 16'd12, 1'b0, 1'b0, 8);
        a1 = 8'd200; b1 = 8'd100; ctrl1 = 2'b00; start1 = 1'b1;
        @(posedge clk); #1;
        start1 = 1'b0;
        wait_done(0, "mul_3_4_midchange");
        repeat (4) @(posedge clk);

        // Reset during iteration 4 aborts silently.
        a1 = 8'd7; b1 = 8'd9; ctrl1 = 2'b10; start1 = 1'b1;
        @(posedge clk); #1;
        start1 = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        check("abort_outputs_zero", {12'd0, y1, c1, err1, busy1, done1}, 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (12) @(posedge clk);
        #1;
        check("abort_no_done_pending", {31'd0, done1}, 32'd0);

        // Back-to-back with start held: second accept happens in the first DONE cycle.
        dcyc.delete();
        ctrl1 = 2'b00; a1 = 8'd1; b1 = 8'd1; start1 = 1'b1;
        @(posedge clk); #1;
        begin
            exp_t e;
            e.y = 16'd2; e.c = 1'b0; e.e = 1'b0; e.lat = 1; e.acc = cyc;
            q1.push_back(e);
        end
        ctrl1 = 2'b10; a1 = 8'd2; b1 = 8'd3;
        @(posedge clk); #1;
        @(posedge clk); #1;
        start1 = 1'b0;
        begin
            exp_t e;
            e.y = 16'd6; e.c = 1'b0; e.e = 1'b0; e.lat = 8; e.acc = cyc;
            q1.push_back(e);
        end
        wait_done(0, "b2b_mul");
        @(posedge clk); #1;
        check("b2b_done_count", dcyc.size(), 32'd2);
        if (dcyc.size() == 2) begin
            check("b2b_done_spacing", dcyc[1] - dcyc[0], 32'd9);
        end else begin
            check("b2b_done_spacing", 32'd0, 32'd9);
        end

        // WIDTH=2 legacy values.
        issue2(2'b00, 2'd2, 2'd1, 16'd3, 1'b0, 1);   wait_done(1, "w2_add_2_1");
        issue2(2'b00, 2'd3, 2'd3, 16'd2, 1'b1, 1);   wait_done(1, "w2_add_3_3");
        issue2(2'b01, 2'd1, 2'd2, 16'd3, 1'b1, 1);   wait_done(1, "w2_sub_1_2");
        issue2(2'b10, 2'd3, 2'd3, 16'd9, 1'b0, 2);   wait_done(1, "w2_mul_3_3");
        issue2(2'b10, 2'd2, 2'd3, 16'd6, 1'b0, 2);   wait_done(1, "w2_mul_2_3");

        repeat (4) @(posedge clk);
        #1;
        check("w8_queue_drained", q1.size(), 32'd0);
        check("w2_queue_drained", q2.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
        $finish;
    end

endmodule
